// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO constants, sizing and parameter-legality helpers
//
// Contents:
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter
//   clog2()              : pointer/count index width
//   is_pow2()            : power-of-two test
//   fifo_params_ok()     : full legality check of a FIFO parameter set
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit fifo_params_ok(input int width, input int depth,
                                        input int af_level, input int ae_level,
                                        input int mode);
    return (width >= 1) && is_pow2(depth) && (depth >= 4) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1) &&
           ((mode == FIFO_STD) || (mode == FIFO_FWFT));
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - simple dual-port register array, sync write, async read
//
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  // Storage is deliberately not reset; the FIFO control discards contents.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with flags and FWFT mode
//
// Ports:
//   CLK, rst_n         : clock, asynchronous active-low reset
//   push, Data_In      : write request and data
//   pop                : read request (FWFT: consume presented head word)
//   Data_Out/Data_Valid: read data and its qualifier
//   Full, Empty        : occupancy flags
//   Almost_Full/Empty  : threshold flags (Count >= AF_LEVEL / Count <= AE_LEVEL)
//   Count              : words held, 0..DEPTH
//   Overflow/Underflow : one-cycle pulses for rejected push/pop
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      Data_In,
  output logic [WIDTH-1:0]      Data_Out,
  output logic                  Data_Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [clog2(DEPTH):0] Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!fifo_params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_param_check
    $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL/FWFT combination");
  end

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, dvalid_q, dvalid_d;
  logic [WIDTH-1:0] dout_q, dout_d, mem_rdata;
  logic [AW-1:0]    mem_raddr;
  logic             push_ok, pop_ok;

  // Standard mode reads the current head on pop; FWFT prefetches the head
  // that will be current after this edge so it can be registered now.
  assign mem_raddr = (FWFT == FIFO_FWFT) ? rd_ptr_d[AW-1:0] : rd_ptr_q[AW-1:0];

  fifo_mem_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (push_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (Data_In),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    push_ok  = push && !full_q;
    pop_ok   = pop && !empty_q;
    wr_ptr_d = push_ok ? (wr_ptr_q + ONE) : wr_ptr_q;
    rd_ptr_d = pop_ok ? (rd_ptr_q + ONE) : rd_ptr_q;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + ONE;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - ONE;
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = push && full_q;
    udf_d   = pop && empty_q;

    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (FWFT == FIFO_FWFT) begin
      dvalid_d = (count_d != '0);
      if (count_d != '0) begin
        // The next head is the word being written this cycle: it is not in
        // the array yet, so forward it straight from the input.
        dout_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? Data_In : mem_rdata;
      end
    end else begin
      dvalid_d = pop_ok;
      if (pop_ok) begin
        dout_d = mem_rdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign Data_Out     = dout_q;
  assign Data_Valid   = dvalid_q;
  assign Full         = full_q;
  assign Empty        = empty_q;
  assign Almost_Full  = af_q;
  assign Almost_Empty = ae_q;
  assign Count        = count_q;
  assign Overflow     = ovf_q;
  assign Underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;

  logic       a_push, a_pop;
  logic [7:0] a_din, a_dout;
  logic       a_dv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0] a_cnt;

  logic       b_push, b_pop;
  logic [7:0] b_din, b_dout;
  logic       b_dv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0] b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)
  ) u_dut_std (
    .CLK(clk), .rst_n(rst_n), .push(a_push), .pop(a_pop), .Data_In(a_din),
    .Data_Out(a_dout), .Data_Valid(a_dv), .Full(a_full), .Empty(a_empty),
    .Almost_Full(a_af), .Almost_Empty(a_ae), .Count(a_cnt),
    .Overflow(a_ovf), .Underflow(a_udf)
  );

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)
  ) u_dut_fwft (
    .CLK(clk), .rst_n(rst_n), .push(b_push), .pop(b_pop), .Data_In(b_din),
    .Data_Out(b_dout), .Data_Valid(b_dv), .Full(b_full), .Empty(b_empty),
    .Almost_Full(b_af), .Almost_Empty(b_ae), .Count(b_cnt),
    .Overflow(b_ovf), .Underflow(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_cnt"},   a_cnt,   0);
    chk({tag, "_empty"}, a_empty, 1);
    chk({tag, "_ae"},    a_ae,    1);
    chk({tag, "_full"},  a_full,  0);
    chk({tag, "_af"},    a_af,    0);
    chk({tag, "_dv"},    a_dv,    0);
    chk({tag, "_dout"},  a_dout,  0);
    chk({tag, "_ovf"},   a_ovf,   0);
    chk({tag, "_udf"},   a_udf,   0);
  endtask

  logic [7:0] sb [$];
  logic [7:0] wdat;
  logic [7:0] exp_d;
  logic       exp_push, exp_pop;

  initial begin
    rst_n  = 1'b0;
    a_push = 1'b0; a_pop = 1'b0; a_din = 8'h00;
    b_push = 1'b0; b_pop = 1'b0; b_din = 8'h00;
    tick(); tick();
    chk_a_idle("rst");
    chk("rst_b_empty", b_empty, 1);
    chk("rst_b_dv",    b_dv,    0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", a_cnt, 0);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      a_push = 1'b1; a_din = 8'(i);
      tick();
      chk("fill_cnt",   a_cnt,   i);
      chk("fill_af",    a_af,    (i >= 12) ? 1 : 0);
      chk("fill_full",  a_full,  (i == 16) ? 1 : 0);
      chk("fill_ae",    a_ae,    (i <= 4) ? 1 : 0);
      chk("fill_empty", a_empty, 0);
    end
    // 17th push is rejected
    a_din = 8'h11;
    tick();
    chk("ovf_pulse", a_ovf, 1);
    chk("ovf_cnt",   a_cnt, 16);
    a_push = 1'b0;
    tick();
    chk("ovf_clear", a_ovf, 0);

    // Drain with idle gaps to see single-cycle Data_Valid pulses
    for (int i = 1; i <= 16; i++) begin
      a_pop = 1'b1;
      tick();
      chk("drain_dv",   a_dv,   1);
      chk("drain_data", a_dout, i);
      chk("drain_cnt",  a_cnt,  16 - i);
      a_pop = 1'b0;
      tick();
      chk("drain_dv_pulse", a_dv,   0);
      chk("drain_hold",     a_dout, i);
    end
    chk("drain_empty", a_empty, 1);
    chk("drain_full",  a_full,  0);

    // Underflow
    a_pop = 1'b1;
    tick();
    chk("udf_pulse", a_udf,  1);
    chk("udf_dv",    a_dv,   0);
    chk("udf_dout",  a_dout, 8'h10);
    chk("udf_cnt",   a_cnt,  0);
    a_pop = 1'b0;
    tick();
    chk("udf_clear", a_udf, 0);

    // Push+pop when empty
    a_push = 1'b1; a_pop = 1'b1; a_din = 8'h20;
    tick();
    chk("pp_empty_cnt", a_cnt, 1);
    chk("pp_empty_udf", a_udf, 1);
    chk("pp_empty_dv",  a_dv,  0);
    a_pop = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      a_din = 8'(8'h20 + i);
      tick();
    end
    chk("pp7_pre_cnt", a_cnt, 7);
    // Push+pop at Count=7
    a_pop = 1'b1; a_din = 8'h27;
    tick();
    chk("pp7_cnt",  a_cnt,  7);
    chk("pp7_dv",   a_dv,   1);
    chk("pp7_data", a_dout, 8'h20);
    a_push = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("pp7_order", a_dout, 8'h20 + i);
    end
    chk("pp7_empty", a_empty, 1);
    a_pop = 1'b0;

    // Push+pop when full
    a_push = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_din = 8'(8'h30 + i);
      tick();
    end
    chk("ppf_pre_full", a_full, 1);
    a_pop = 1'b1; a_din = 8'h40;
    tick();
    chk("ppf_cnt",  a_cnt,  15);
    chk("ppf_ovf",  a_ovf,  1);
    chk("ppf_data", a_dout, 8'h30);
    chk("ppf_full", a_full, 0);
    a_push = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("ppf_order", a_dout, 8'h30 + i);
    end
    chk("ppf_empty", a_empty, 1);
    a_pop = 1'b0;
    tick();

    // Wrap-around: interleaved traffic against a queue scoreboard
    wdat = 8'h50;
    for (int k = 0; k < 40; k++) begin
      a_push = ((k % 4) != 3);
      a_pop  = ((k % 3) != 0);
      a_din  = wdat;
      exp_push = a_push && (sb.size() < 16);
      exp_pop  = a_pop && (sb.size() > 0);
      tick();
      if (exp_pop) begin
        exp_d = sb.pop_front();
        chk("wrap_dv",   a_dv,   1);
        chk("wrap_data", a_dout, exp_d);
      end else begin
        chk("wrap_dv", a_dv, 0);
      end
      if (exp_push) begin
        sb.push_back(wdat);
        wdat = wdat + 8'h01;
      end
      chk("wrap_cnt", a_cnt, sb.size());
    end
    a_push = 1'b0;
    a_pop  = 1'b1;
    while (sb.size() > 0) begin
      exp_d = sb.pop_front();
      tick();
      chk("wrap_tail", a_dout, exp_d);
    end
    a_pop = 1'b0;
    tick();
    chk("wrap_empty", a_empty, 1);

    // FWFT
    b_push = 1'b1; b_din = 8'hA5;
    tick();
    chk("fw_first_data",  b_dout,  8'hA5);
    chk("fw_first_dv",    b_dv,    1);
    chk("fw_first_empty", b_empty, 0);
    chk("fw_first_cnt",   b_cnt,   1);
    b_din = 8'h3C;
    tick();
    chk("fw_second_head", b_dout, 8'hA5);
    chk("fw_second_cnt",  b_cnt,  2);
    b_push = 1'b0; b_pop = 1'b1;
    tick();
    chk("fw_pop1_data", b_dout, 8'h3C);
    chk("fw_pop1_dv",   b_dv,   1);
    chk("fw_pop1_cnt",  b_cnt,  1);
    tick();
    chk("fw_pop2_dv",    b_dv,    0);
    chk("fw_pop2_empty", b_empty, 1);
    b_pop = 1'b0;
    // No bubble across back-to-back pops
    b_push = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b_din = 8'(i);
      tick();
    end
    b_push = 1'b0; b_pop = 1'b1;
    chk("fw_nb_head", b_dout, 1);
    tick();
    chk("fw_nb_2", b_dout, 2);
    chk("fw_nb_2v", b_dv, 1);
    tick();
    chk("fw_nb_3", b_dout, 3);
    chk("fw_nb_3v", b_dv, 1);
    tick();
    chk("fw_nb_end", b_empty, 1);
    // Push and pop with one word held: new word forwarded as head
    b_pop = 1'b0; b_push = 1'b1; b_din = 8'h11;
    tick();
    b_pop = 1'b1; b_din = 8'h22;
    tick();
    chk("fw_fwd_data", b_dout, 8'h22);
    chk("fw_fwd_dv",   b_dv,   1);
    chk("fw_fwd_cnt",  b_cnt,  1);
    b_push = 1'b0; b_pop = 1'b0;
    tick();

    // Asynchronous reset mid-stream with Count=5
    a_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_din = 8'(8'h60 + i);
      tick();
    end
    a_push = 1'b0;
    a_pop  = 1'b1;
    tick();
    a_pop  = 1'b0;
    a_push = 1'b1; a_din = 8'h65;
    tick();
    a_push = 1'b0;
    chk("mid_pre_cnt", a_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    chk_a_idle("mid_rst");
    chk("mid_rst_b_dv", b_dv, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("mid_post_cnt",   a_cnt,   0);
    chk("mid_post_empty", a_empty, 1);
    a_push = 1'b1; a_din = 8'h77;
    tick();
    a_push = 1'b0; a_pop = 1'b1;
    tick();
    chk("mid_post_data", a_dout, 8'h77);
    chk("mid_post_cnt2", a_cnt,  0);
    a_pop = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
